// File: rtl/hy_sram_port_arbiter_pkg.sv
// Shared constants and the pipeline tag for the two-port SRAM arbiter.
package hy_sram_pkg;

  localparam int SRAM_ADDR_W = 10;
  localparam int SRAM_DATA_W = 32;

  localparam logic PORT_IFETCH = 1'b0;
  localparam logic PORT_LSU    = 1'b1;

  typedef struct packed {
    logic valid;
    logic port;
    logic we;
  } pipe_tag_t;

  localparam pipe_tag_t TAG_IDLE = '{valid: 1'b0, port: 1'b0, we: 1'b0};

endpackage

// File: rtl/hy_sram_port_arbiter_arb2.sv
// Two-way grant logic: round-robin or fixed priority with a port-0 starvation guard.
module hy_arb2 #(
  parameter int PRIORITY_MODE = 0,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req_valid,
  input  logic       accept,
  output logic [1:0] grant
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic       last_grant_q, last_grant_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       conflict;

  always_comb begin
    conflict     = &req_valid;
    grant        = req_valid;
    last_grant_d = last_grant_q;
    starve_cnt_d = starve_cnt_q;

    if (conflict) begin
      if (PRIORITY_MODE == 0) begin
        grant = last_grant_q ? 2'b01 : 2'b10;
      end else begin
        grant = (starve_cnt_q == LIMIT) ? 2'b01 : 2'b10;
      end
    end

    if (accept) begin
      last_grant_d = grant[1];
    end

    // Counter only tracks consecutive port-0 losses while port 0 keeps asking.
    if (PRIORITY_MODE != 0) begin
      if (!req_valid[0] || (accept && grant[0])) begin
        starve_cnt_d = 4'd0;
      end else if (accept && conflict) begin
        starve_cnt_d = starve_cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= 1'b1;
      starve_cnt_q <= 4'd0;
    end else begin
      last_grant_q <= last_grant_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/hy_sram_port_arbiter.sv
// Shares one synchronous single-port SRAM between instruction fetch (port 0) and load/store (port 1).
module hy_sram_port_arbiter
  import hy_sram_pkg::*;
#(
  parameter int ADDR_W        = SRAM_ADDR_W,
  parameter int DATA_W        = SRAM_DATA_W,
  parameter int PRIORITY_MODE = 0,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic              p0_req_valid,
  output logic              p0_req_ready,
  input  logic              p0_req_we,
  input  logic [ADDR_W-1:0] p0_req_addr,
  input  logic [DATA_W-1:0] p0_req_wdata,
  output logic              p0_rsp_valid,
  output logic [DATA_W-1:0] p0_rsp_rdata,

  input  logic              p1_req_valid,
  output logic              p1_req_ready,
  input  logic              p1_req_we,
  input  logic [ADDR_W-1:0] p1_req_addr,
  input  logic [DATA_W-1:0] p1_req_wdata,
  output logic              p1_rsp_valid,
  output logic [DATA_W-1:0] p1_rsp_rdata,

  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_data_in,
  input  logic [DATA_W-1:0] sram_data_out,

  output logic              busy
);

  logic [1:0]        grant;
  logic              accept;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic [DATA_W-1:0] rsp_data;

  pipe_tag_t         s1_q, s1_d, s2_q, s2_d;
  logic              sram_we_q, sram_we_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [DATA_W-1:0] sram_data_in_q, sram_data_in_d;

  hy_arb2 #(
    .PRIORITY_MODE (PRIORITY_MODE),
    .STARVE_LIMIT  (STARVE_LIMIT)
  ) u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid ({p1_req_valid, p0_req_valid}),
    .accept    (accept),
    .grant     (grant)
  );

  // Ready is forced low during reset so nothing appears accepted while flops are held.
  assign p0_req_ready = grant[0] & reset_n;
  assign p1_req_ready = grant[1] & reset_n;
  assign accept       = p0_req_ready | p1_req_ready;

  always_comb begin
    win_we    = p1_req_ready ? p1_req_we    : p0_req_we;
    win_addr  = p1_req_ready ? p1_req_addr  : p0_req_addr;
    win_wdata = p1_req_ready ? p1_req_wdata : p0_req_wdata;

    s1_d           = TAG_IDLE;
    s1_d.valid     = accept;
    s1_d.port      = p1_req_ready ? PORT_LSU : PORT_IFETCH;
    s1_d.we        = win_we;
    s2_d           = s1_q;
    sram_we_d      = accept & win_we;
    sram_addr_d    = accept ? win_addr : sram_addr_q;
    sram_data_in_d = accept ? win_wdata : sram_data_in_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q           <= TAG_IDLE;
      s2_q           <= TAG_IDLE;
      sram_we_q      <= 1'b0;
      sram_addr_q    <= '0;
      sram_data_in_q <= '0;
    end else begin
      s1_q           <= s1_d;
      s2_q           <= s2_d;
      sram_we_q      <= sram_we_d;
      sram_addr_q    <= sram_addr_d;
      sram_data_in_q <= sram_data_in_d;
    end
  end

  assign sram_we      = sram_we_q;
  assign sram_addr    = sram_addr_q;
  assign sram_data_in = sram_data_in_q;

  // SRAM read data lines up with the S2 tag; writes are acknowledged with zero data.
  assign rsp_data     = s2_q.we ? '0 : sram_data_out;
  assign p0_rsp_valid = s2_q.valid & (s2_q.port == PORT_IFETCH);
  assign p1_rsp_valid = s2_q.valid & (s2_q.port == PORT_LSU);
  assign p0_rsp_rdata = p0_rsp_valid ? rsp_data : '0;
  assign p1_rsp_rdata = p1_rsp_valid ? rsp_data : '0;

  assign busy = p0_req_valid | p1_req_valid | s1_q.valid | s2_q.valid;

endmodule

// File: tb/tb_hy_sram_port_arbiter.sv
// Bench for hy_sram_port_arbiter: round-robin instance with SRAM model and response scoreboard, plus a fixed-priority instance for grant patterns.
module tb_hy_sram_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        p0_req_valid, p0_req_we, p1_req_valid, p1_req_we;
  logic [9:0]  p0_req_addr, p1_req_addr;
  logic [31:0] p0_req_wdata, p1_req_wdata;

  logic        p0_req_ready, p1_req_ready, p0_rsp_valid, p1_rsp_valid;
  logic [31:0] p0_rsp_rdata, p1_rsp_rdata;
  logic        sram_we, busy;
  logic [9:0]  sram_addr;
  logic [31:0] sram_data_in;
  logic [31:0] sram_dout = 32'h0;

  logic        f_p0_req_ready, f_p1_req_ready, f_p0_rsp_valid, f_p1_rsp_valid;
  logic [31:0] f_p0_rsp_rdata, f_p1_rsp_rdata;
  logic        f_sram_we, f_busy;
  logic [9:0]  f_sram_addr;
  logic [31:0] f_sram_data_in;
  logic [31:0] f_sram_dout = 32'h0;

  hy_sram_port_arbiter #(.ADDR_W(10), .DATA_W(32), .PRIORITY_MODE(0), .STARVE_LIMIT(4)) u_rr (
    .clk(clk), .reset_n(reset_n),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_we(p0_req_we),
    .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata),
    .p0_rsp_valid(p0_rsp_valid), .p0_rsp_rdata(p0_rsp_rdata),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_we(p1_req_we),
    .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata),
    .p1_rsp_valid(p1_rsp_valid), .p1_rsp_rdata(p1_rsp_rdata),
    .sram_we(sram_we), .sram_addr(sram_addr), .sram_data_in(sram_data_in),
    .sram_data_out(sram_dout), .busy(busy)
  );

  hy_sram_port_arbiter #(.ADDR_W(10), .DATA_W(32), .PRIORITY_MODE(1), .STARVE_LIMIT(4)) u_fp (
    .clk(clk), .reset_n(reset_n),
    .p0_req_valid(p0_req_valid), .p0_req_ready(f_p0_req_ready), .p0_req_we(p0_req_we),
    .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata),
    .p0_rsp_valid(f_p0_rsp_valid), .p0_rsp_rdata(f_p0_rsp_rdata),
    .p1_req_valid(p1_req_valid), .p1_req_ready(f_p1_req_ready), .p1_req_we(p1_req_we),
    .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata),
    .p1_rsp_valid(f_p1_rsp_valid), .p1_rsp_rdata(f_p1_rsp_rdata),
    .sram_we(f_sram_we), .sram_addr(f_sram_addr), .sram_data_in(f_sram_data_in),
    .sram_data_out(f_sram_dout), .busy(f_busy)
  );

  // SRAM model: 1024 x 32, synchronous read, preloaded on the first edge (inside reset).
  logic [31:0] mem [0:1023];
  bit preload_done = 1'b0;
  always @(posedge clk) begin
    if (!preload_done) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
      mem[10'h010] <= 32'hDEADBEEF;
      preload_done <= 1'b1;
    end else if (sram_we) begin
      mem[sram_addr] <= sram_data_in;
    end
    sram_dout <= mem[sram_addr];
  end

  typedef struct {
    int          due;
    logic        port;
    logic [31:0] rdata;
  } exp_t;
  exp_t q[$];

  typedef struct {
    logic        p0v, p0we;
    logic [9:0]  p0a;
    logic [31:0] p0d;
    logic        p1v, p1we;
    logic [9:0]  p1a;
    logic [31:0] p1d;
    logic        e0, e1;
  } vec_t;
  vec_t vecs[11];

  logic [31:0] ref_mem [0:1023];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic vec_t mkv(input logic p0v, p0we, input logic [9:0] p0a, input logic [31:0] p0d,
                               input logic p1v, p1we, input logic [9:0] p1a, input logic [31:0] p1d,
                               input logic e0, e1);
    vec_t v;
    v.p0v = p0v; v.p0we = p0we; v.p0a = p0a; v.p0d = p0d;
    v.p1v = p1v; v.p1we = p1we; v.p1a = p1a; v.p1d = p1d;
    v.e0 = e0; v.e1 = e1;
    return v;
  endfunction

  task automatic drive(input logic p0v, p0we, input logic [9:0] p0a, input logic [31:0] p0d,
                       input logic p1v, p1we, input logic [9:0] p1a, input logic [31:0] p1d);
    p0_req_valid = p0v; p0_req_we = p0we; p0_req_addr = p0a; p0_req_wdata = p0d;
    p1_req_valid = p1v; p1_req_we = p1we; p1_req_addr = p1a; p1_req_wdata = p1d;
  endtask

  task automatic push_exp(input logic port);
    exp_t e;
    logic        we;
    logic [9:0]  a;
    logic [31:0] d;
    we = port ? p1_req_we : p0_req_we;
    a  = port ? p1_req_addr : p0_req_addr;
    d  = port ? p1_req_wdata : p0_req_wdata;
    e.due  = cyc + 2;
    e.port = port;
    if (we) begin
      ref_mem[a] = d;
      e.rdata = 32'h0;
    end else begin
      e.rdata = ref_mem[a];
    end
    q.push_back(e);
  endtask

  task automatic check_rsp();
    exp_t e;
    while (q.size() > 0 && q[0].due < cyc) begin
      checks++;
      errors++;
      $display("FAIL rsp_missing: port %0d response due cycle %0d not seen (cycle %0d)", q[0].port, q[0].due, cyc);
      void'(q.pop_front());
    end
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      if (e.port == 1'b0) begin
        chk("p0_rsp_valid", 32'(p0_rsp_valid), 32'd1);
        chk("p0_rsp_rdata", p0_rsp_rdata, e.rdata);
        chk("p1_rsp_idle",  32'(p1_rsp_valid), 32'd0);
      end else begin
        chk("p1_rsp_valid", 32'(p1_rsp_valid), 32'd1);
        chk("p1_rsp_rdata", p1_rsp_rdata, e.rdata);
        chk("p0_rsp_idle",  32'(p0_rsp_valid), 32'd0);
      end
    end else begin
      chk("p0_rsp_idle", 32'(p0_rsp_valid), 32'd0);
      chk("p1_rsp_idle", 32'(p1_rsp_valid), 32'd0);
    end
  endtask

  // Called at posedge+1; checks mid-cycle, then advances to the next posedge+1.
  task automatic tick(input logic e0, input logic e1, input bit chk_fp,
                      input logic f0, input logic f1, input bit do_push);
    @(negedge clk);
    chk("rr_p0_ready", 32'(p0_req_ready), 32'(e0));
    chk("rr_p1_ready", 32'(p1_req_ready), 32'(e1));
    if (chk_fp) begin
      chk("fp_p0_ready", 32'(f_p0_req_ready), 32'(f0));
      chk("fp_p1_ready", 32'(f_p1_req_ready), 32'(f1));
    end
    if (do_push) begin
      if (e0) push_exp(1'b0);
      if (e1) push_exp(1'b1);
    end
    check_rsp();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
    ref_mem[10'h010] = 32'hDEADBEEF;

    vecs[0]  = mkv(0,0,10'h000,32'h0,         1,1,10'h3FF,32'h12345678, 0,1);
    vecs[1]  = mkv(1,0,10'h3FF,32'h0,         0,0,10'h000,32'h0,        1,0);
    vecs[2]  = mkv(0,0,10'h000,32'h0,         1,1,10'h020,32'hA5A50001, 0,1);
    vecs[3]  = mkv(1,0,10'h010,32'h0,         1,0,10'h020,32'h0,        1,0);
    vecs[4]  = mkv(1,0,10'h3FF,32'h0,         1,0,10'h020,32'h0,        0,1);
    vecs[5]  = mkv(1,0,10'h3FF,32'h0,         1,1,10'h030,32'hCAFE0003, 1,0);
    vecs[6]  = mkv(1,1,10'h040,32'h11112222,  1,1,10'h030,32'hCAFE0003, 0,1);
    vecs[7]  = mkv(1,1,10'h040,32'h11112222,  0,0,10'h000,32'h0,        1,0);
    vecs[8]  = mkv(1,0,10'h040,32'h0,         1,0,10'h030,32'h0,        0,1);
    vecs[9]  = mkv(1,0,10'h040,32'h0,         0,0,10'h000,32'h0,        1,0);
    vecs[10] = mkv(0,0,10'h000,32'h0,         0,0,10'h000,32'h0,        0,0);

    // Reset values
    reset_n = 1'b0;
    drive(0,0,10'h0,32'h0, 0,0,10'h0,32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sram_we",   32'(sram_we), 32'd0);
    chk("rst_sram_addr", 32'(sram_addr), 32'd0);
    chk("rst_sram_din",  sram_data_in, 32'd0);
    chk("rst_p0_rsp",    32'(p0_rsp_valid), 32'd0);
    chk("rst_p1_rsp",    32'(p1_rsp_valid), 32'd0);
    chk("rst_p0_rdata",  p0_rsp_rdata, 32'd0);
    chk("rst_busy",      32'(busy), 32'd0);
    reset_n = 1'b1;

    // Single p0 read of preloaded word
    drive(1,0,10'h010,32'h0, 0,0,10'h0,32'h0);
    tick(1,0, 1,1,0, 1);
    drive(0,0,10'h0,32'h0, 0,0,10'h0,32'h0);
    chk("t1_sram_addr", 32'(sram_addr), 32'h010);
    chk("t1_sram_we",   32'(sram_we), 32'd0);
    chk("t1_busy",      32'(busy), 32'd1);
    tick(0,0, 0,0,0, 1);
    tick(0,0, 0,0,0, 1);

    // Round-robin vectors: write/read hazard, alternating conflicts
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].p0v, vecs[i].p0we, vecs[i].p0a, vecs[i].p0d,
            vecs[i].p1v, vecs[i].p1we, vecs[i].p1a, vecs[i].p1d);
      tick(vecs[i].e0, vecs[i].e1, 0,0,0, 1);
    end
    repeat (3) tick(0,0, 0,0,0, 1);

    // Idle after a write
    drive(0,0,10'h0,32'h0, 1,1,10'h055,32'h0BADF00D);
    tick(0,1, 0,0,0, 1);
    drive(0,0,10'h0,32'h0, 0,0,10'h0,32'h0);
    chk("t6_we_s1",   32'(sram_we), 32'd1);
    chk("t6_addr_s1", 32'(sram_addr), 32'h055);
    chk("t6_din_s1",  sram_data_in, 32'h0BADF00D);
    tick(0,0, 0,0,0, 1);
    chk("t6_we_idle",   32'(sram_we), 32'd0);
    chk("t6_addr_hold", 32'(sram_addr), 32'h055);
    chk("t6_busy_s2",   32'(busy), 32'd1);
    tick(0,0, 0,0,0, 1);
    chk("t6_busy_done", 32'(busy), 32'd0);
    chk("t6_addr_hold2", 32'(sram_addr), 32'h055);
    chk("t6_din_hold",  sram_data_in, 32'h0BADF00D);
    tick(0,0, 0,0,0, 1);

    // Continuous conflict: RR alternates, fixed priority gives p0 every 5th grant
    drive(1,0,10'h010,32'h0, 1,0,10'h020,32'h0);
    for (int i = 0; i < 10; i++) begin
      tick((i % 2) == 0, (i % 2) == 1, 1, (i % 5) == 4, (i % 5) != 4, 1);
    end
    drive(0,0,10'h0,32'h0, 0,0,10'h0,32'h0);
    repeat (3) tick(0,0, 0,0,0, 1);

    // Reset mid-operation: write on the SRAM pins, read just granted
    drive(0,0,10'h0,32'h0, 1,1,10'h066,32'h00000077);
    tick(0,1, 0,0,0, 0);
    drive(1,0,10'h010,32'h0, 0,0,10'h0,32'h0);
    chk("t5_we_before", 32'(sram_we), 32'd1);
    @(negedge clk);
    chk("t5_p0_ready", 32'(p0_req_ready), 32'd1);
    check_rsp();
    reset_n = 1'b0;
    #1;
    chk("t5_we_async",  32'(sram_we), 32'd0);
    chk("t5_addr_rst",  32'(sram_addr), 32'd0);
    chk("t5_ready_rst", 32'(p0_req_ready), 32'd0);
    drive(0,0,10'h0,32'h0, 0,0,10'h0,32'h0);
    @(posedge clk);
    cyc++;
    #1;
    tick(0,0, 0,0,0, 0);
    tick(0,0, 0,0,0, 0);
    chk("t5_busy_rst", 32'(busy), 32'd0);
    reset_n = 1'b1;
    drive(1,0,10'h010,32'h0, 1,0,10'h020,32'h0);
    tick(1,0, 1,0,1, 1);
    drive(0,0,10'h0,32'h0, 0,0,10'h0,32'h0);
    repeat (3) tick(0,0, 0,0,0, 1);
    chk("mem_066_untouched", mem[10'h066], 32'h0);
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
